// File: rtl/envm_pattern_fault_store.sv
// Embedded-NVM model for the self-test path: stores per-type scan patterns, streams them over a
// valid/ready handshake and accumulates sticky PE/row/column fault maps for recovery logic.
module envm_pattern_fault_store #(
    parameter int unsigned SYSTOLIC_SIZE     = 8,
    parameter int unsigned WEIGHT_WIDTH      = 8,
    parameter int unsigned ACTIVATION_WIDTH  = 8,
    parameter int unsigned PARTIAL_SUM_WIDTH =
        WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int unsigned NUM_TEST_TYPES    = 2,
    parameter int unsigned PATTERN_DEPTH     = 32,
    localparam int unsigned TYPE_W  = (NUM_TEST_TYPES > 1) ? $clog2(NUM_TEST_TYPES) : 1,
    localparam int unsigned PADDR_W = $clog2(PATTERN_DEPTH),
    localparam int unsigned ROW_W   = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1,
    localparam int unsigned PCNT_W  = $clog2(SYSTOLIC_SIZE * SYSTOLIC_SIZE + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   load_en,
    input  logic [TYPE_W-1:0]                      load_type,
    input  logic [PADDR_W-1:0]                     load_addr,
    input  logic [WEIGHT_WIDTH-1:0]                load_weight,
    input  logic [ACTIVATION_WIDTH-1:0]            load_activation,
    input  logic [PARTIAL_SUM_WIDTH-1:0]           load_answer,
    output logic                                   load_err,
    input  logic                                   start,
    input  logic [TYPE_W-1:0]                      test_type,
    input  logic [PADDR_W:0]                       pattern_count,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [PADDR_W-1:0]                     out_index,
    output logic                                   out_last,
    output logic [WEIGHT_WIDTH-1:0]                Scan_data_weight,
    output logic [ACTIVATION_WIDTH-1:0]            Scan_data_activation,
    output logic [PARTIAL_SUM_WIDTH-1:0]           Scan_data_answer,
    output logic                                   busy,
    output logic                                   done,
    input  logic                                   detection_en,
    input  logic [ROW_W-1:0]                       counter,
    input  logic [SYSTOLIC_SIZE-1:0]               single_pe_detection,
    input  logic                                   row_fault_detection,
    input  logic                                   column_fault_detection,
    input  logic                                   fault_clear,
    output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] envm_faulty_patterns_flat,
    output logic [SYSTOLIC_SIZE-1:0]               faulty_row_flat,
    output logic [SYSTOLIC_SIZE-1:0]               faulty_column_flat,
    output logic [PCNT_W-1:0]                      fault_pe_count
);

    localparam int unsigned CNT_W   = PADDR_W + 1;
    localparam int unsigned ENTRY_W = WEIGHT_WIDTH + ACTIVATION_WIDTH + PARTIAL_SUM_WIDTH;
    localparam int unsigned NN      = SYSTOLIC_SIZE * SYSTOLIC_SIZE;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(PATTERN_DEPTH);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e             state_q;
    logic [TYPE_W-1:0]  type_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PADDR_W-1:0] index_q;
    logic               load_err_q;

    // Pattern store has no reset: contents survive rst like the NVM it models.
    logic [ENTRY_W-1:0] mem [NUM_TEST_TYPES][PATTERN_DEPTH];

    logic               load_ok;
    logic               start_type_ok;
    logic [CNT_W-1:0]   start_cnt;
    logic               last;
    logic [ENTRY_W-1:0] rd_entry;

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign out_valid = (state_q == StStream);
    assign out_index = index_q;
    assign load_err  = load_err_q;

    assign load_ok = (32'(load_addr) < PATTERN_DEPTH) && (32'(load_type) < NUM_TEST_TYPES) &&
                     !(busy && (load_type == type_q));

    assign start_type_ok = (32'(test_type) < NUM_TEST_TYPES);
    assign start_cnt     = (pattern_count > DEPTH_CNT) ? DEPTH_CNT : pattern_count;
    assign last          = out_valid && ({1'b0, index_q} == (cnt_q - CNT_W'(1)));
    assign out_last      = last;

    always_ff @(posedge clk) begin
        if (load_en && load_ok) begin
            mem[load_type][load_addr] <= {load_weight, load_activation, load_answer};
        end
    end

    assign rd_entry = out_valid ? mem[type_q][index_q] : '0;
    assign {Scan_data_weight, Scan_data_activation, Scan_data_answer} = rd_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            type_q     <= '0;
            cnt_q      <= '0;
            index_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_en && !load_ok;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        type_q  <= test_type;
                        cnt_q   <= start_cnt;
                        index_q <= '0;
                        state_q <= ((start_cnt == '0) || !start_type_ok) ? StDone : StStream;
                    end
                end
                StStream: begin
                    if (out_ready) begin
                        index_q <= index_q + PADDR_W'(1);
                        if (last) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    index_q <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [NN-1:0]            pe_q, pe_d;
    logic [SYSTOLIC_SIZE-1:0] row_q, row_d;
    logic [SYSTOLIC_SIZE-1:0] col_q, col_d;
    logic                     det_ok;

    assign det_ok = detection_en && (32'(counter) < SYSTOLIC_SIZE);

    // Clear takes effect first so a same-cycle capture lands in an empty map.
    always_comb begin
        pe_d  = fault_clear ? '0 : pe_q;
        row_d = fault_clear ? '0 : row_q;
        col_d = fault_clear ? '0 : col_q;
        if (det_ok) begin
            pe_d[32'(counter)*SYSTOLIC_SIZE +: SYSTOLIC_SIZE] =
                pe_d[32'(counter)*SYSTOLIC_SIZE +: SYSTOLIC_SIZE] | single_pe_detection;
            row_d[counter] = row_d[counter] | row_fault_detection;
            col_d[counter] = col_d[counter] | column_fault_detection;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            pe_q  <= pe_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    always_comb begin
        fault_pe_count = '0;
        for (int i = 0; i < int'(NN); i++) begin
            fault_pe_count = fault_pe_count + PCNT_W'(pe_q[i]);
        end
    end

    assign envm_faulty_patterns_flat = pe_q;
    assign faulty_row_flat           = row_q;
    assign faulty_column_flat        = col_q;

endmodule

// File: tb/tb_envm_pattern_fault_store.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor pops and compares them.
module tb_envm_pattern_fault_store;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int A  = 8;
    localparam int P  = 19;
    localparam int NT = 2;
    localparam int D  = 32;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic          load_type;
    logic [PW-1:0] load_addr;
    logic [W-1:0]  load_weight;
    logic [A-1:0]  load_activation;
    logic [P-1:0]  load_answer;
    logic          load_err;
    logic          start;
    logic          test_type;
    logic [PW:0]   pattern_count;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_index;
    logic          out_last;
    logic [W-1:0]  Scan_data_weight;
    logic [A-1:0]  Scan_data_activation;
    logic [P-1:0]  Scan_data_answer;
    logic          busy;
    logic          done;
    logic          detection_en;
    logic [2:0]    counter;
    logic [N-1:0]  single_pe_detection;
    logic          row_fault_detection;
    logic          column_fault_detection;
    logic          fault_clear;
    logic [N*N-1:0] envm_faulty_patterns_flat;
    logic [N-1:0]  faulty_row_flat;
    logic [N-1:0]  faulty_column_flat;
    logic [6:0]    fault_pe_count;

    envm_pattern_fault_store dut (
        .clk                       (clk),
        .rst                       (rst),
        .load_en                   (load_en),
        .load_type                 (load_type),
        .load_addr                 (load_addr),
        .load_weight               (load_weight),
        .load_activation           (load_activation),
        .load_answer               (load_answer),
        .load_err                  (load_err),
        .start                     (start),
        .test_type                 (test_type),
        .pattern_count             (pattern_count),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_index                 (out_index),
        .out_last                  (out_last),
        .Scan_data_weight          (Scan_data_weight),
        .Scan_data_activation      (Scan_data_activation),
        .Scan_data_answer          (Scan_data_answer),
        .busy                      (busy),
        .done                      (done),
        .detection_en              (detection_en),
        .counter                   (counter),
        .single_pe_detection       (single_pe_detection),
        .row_fault_detection       (row_fault_detection),
        .column_fault_detection    (column_fault_detection),
        .fault_clear               (fault_clear),
        .envm_faulty_patterns_flat (envm_faulty_patterns_flat),
        .faulty_row_flat           (faulty_row_flat),
        .faulty_column_flat        (faulty_column_flat),
        .fault_pe_count            (fault_pe_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] idx;
        logic          last;
        logic [W-1:0]  w;
        logic [A-1:0]  a;
        logic [P-1:0]  ans;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] mw   [NT][D];
    logic [A-1:0] ma   [NT][D];
    logic [P-1:0] mans [NT][D];

    int n_cmp    = 0;
    int n_err    = 0;
    int beats    = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid cycle is compared with the head of the queue; a pop only on ready.
    beat_t act_b;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got index %0d, no beat expected", out_index);
            end else begin
                act_b = {out_index, out_last, Scan_data_weight, Scan_data_activation,
                         Scan_data_answer};
                check("beat", 64'(act_b), 64'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end else begin
            check("idle_zero", 64'({out_last, Scan_data_weight, Scan_data_activation,
                                    Scan_data_answer}), 64'(0));
        end
    end

    task automatic load(input int t, input int ad, input logic [W-1:0] w, input logic [A-1:0] a,
                        input logic [P-1:0] ans, input bit accept);
        load_en         = 1'b1;
        load_type       = 1'(t);
        load_addr       = PW'(ad);
        load_weight     = w;
        load_activation = a;
        load_answer     = ans;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        check("load_err", 64'(load_err), accept ? 64'(0) : 64'(1));
        if (accept) begin
            mw[t][ad]   = w;
            ma[t][ad]   = a;
            mans[t][ad] = ans;
        end
    endtask

    task automatic start_stream(input int t, input int cnt);
        beat_t e;
        int n;
        n = (cnt > D) ? D : cnt;
        for (int i = 0; i < n; i++) begin
            e.idx  = PW'(i);
            e.last = (i == n - 1);
            e.w    = mw[t][i];
            e.a    = ma[t][i];
            e.ans  = mans[t][i];
            exp_q.push_back(e);
        end
        start         = 1'b1;
        test_type     = 1'(t);
        pattern_count = 6'(cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        int k;
        base = done_cnt;
        k    = 0;
        while (done_cnt == base && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done_cnt == base) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done: no done pulse within %0d cycles", budget);
        end
    endtask

    task automatic detect(input int row, input logic [N-1:0] pe, input bit rf, input bit cf,
                          input bit en, input bit clr);
        detection_en           = en;
        counter                = 3'(row);
        single_pe_detection    = pe;
        row_fault_detection    = rf;
        column_fault_detection = cf;
        fault_clear            = clr;
        @(posedge clk);
        #1;
        detection_en           = 1'b0;
        fault_clear            = 1'b0;
        single_pe_detection    = '0;
        row_fault_detection    = 1'b0;
        column_fault_detection = 1'b0;
    endtask

    task automatic check_faults(input string tag, input logic [63:0] pe, input int cnt,
                                input logic [7:0] rows, input logic [7:0] cols);
        check({tag, "_pe"}, envm_faulty_patterns_flat, pe);
        check({tag, "_cnt"}, 64'(fault_pe_count), 64'(cnt));
        check({tag, "_row"}, 64'(faulty_row_flat), 64'(rows));
        check({tag, "_col"}, 64'(faulty_column_flat), 64'(cols));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, u0;
        rst = 1'b1;
        load_en = 1'b0; load_type = 1'b0; load_addr = '0;
        load_weight = '0; load_activation = '0; load_answer = '0;
        start = 1'b0; test_type = 1'b0; pattern_count = '0; out_ready = 1'b1;
        detection_en = 1'b0; counter = '0; single_pe_detection = '0;
        row_fault_detection = 1'b0; column_fault_detection = 1'b0; fault_clear = 1'b0;

        #12;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_load_err", 64'(load_err), 64'(0));
        check("rst_index", 64'(out_index), 64'(0));
        check_faults("rst", 64'h0, 0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Type 0 entry i = (3i+1, 3i+2, 3i+3); type 1 entry i = (A0+i, 50+i, 10000+i).
        for (int i = 0; i < D; i++) begin
            load(0, i, W'(3 * i + 1), A'(3 * i + 2), P'(3 * i + 3), 1'b1);
            load(1, i, W'(8'hA0 + i), A'(8'h50 + i), P'(19'h10000 + i), 1'b1);
        end

        // 1: three beats at full throughput
        b0 = beats; d0 = done_cnt; u0 = busy_cnt;
        start_stream(0, 3);
        wait_done(20);
        check("t1_beats", 64'(beats - b0), 64'(3));
        check("t1_done", 64'(done_cnt - d0), 64'(1));
        check("t1_busy", 64'(busy_cnt - u0), 64'(4));
        check("t1_drain", 64'(exp_q.size()), 64'(0));

        // 2: ready 1,0,0,1 then held high
        b0 = beats; u0 = busy_cnt;
        start_stream(0, 3);
        for (int k = 0; k < 5; k++) begin
            out_ready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_done(20);
        check("t2_beats", 64'(beats - b0), 64'(3));
        check("t2_busy", 64'(busy_cnt - u0), 64'(6));
        check("t2_drain", 64'(exp_q.size()), 64'(0));

        // 3: zero-length stream, then a request clipped to the depth
        b0 = beats; d0 = done_cnt; u0 = busy_cnt;
        start_stream(0, 0);
        wait_done(5);
        check("t3_zero_beats", 64'(beats - b0), 64'(0));
        check("t3_zero_done", 64'(done_cnt - d0), 64'(1));
        check("t3_zero_busy", 64'(busy_cnt - u0), 64'(1));
        b0 = beats; u0 = busy_cnt;
        start_stream(1, 40);
        wait_done(100);
        check("t3_clip_beats", 64'(beats - b0), 64'(32));
        check("t3_clip_busy", 64'(busy_cnt - u0), 64'(33));
        check("t3_drain", 64'(exp_q.size()), 64'(0));

        // 4: write collisions while streaming type 1
        out_ready = 1'b0;
        start_stream(1, 4);
        load(1, 5, 8'hEE, 8'hEE, 19'h7EEEE, 1'b0);
        @(posedge clk);
        #1;
        check("t4_err_pulse", 64'(load_err), 64'(0));
        load(0, 7, 8'h5A, 8'hC3, 19'h12345, 1'b1);
        out_ready = 1'b1;
        wait_done(20);
        start_stream(1, 6);
        wait_done(20);
        start_stream(0, 8);
        wait_done(20);
        check("t4_drain", 64'(exp_q.size()), 64'(0));

        // 5: fault map accumulation and clear-with-capture
        detect(2, 8'h81, 1'b1, 1'b0, 1'b1, 1'b0);
        check_faults("t5a", 64'h0000_0000_0081_0000, 2, 8'h04, 8'h00);
        detect(2, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0);
        check_faults("t5b", 64'h0000_0000_0091_0000, 3, 8'h04, 8'h04);
        detect(7, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        check_faults("t5c", 64'hFF00_0000_0091_0000, 11, 8'h84, 8'h04);
        detect(2, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        check_faults("t5d", 64'h0000_0000_0001_0000, 1, 8'h00, 8'h00);
        detect(5, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        check_faults("t5e", 64'h0000_0000_0001_0000, 1, 8'h00, 8'h00);
        detect(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_faults("t5f", 64'h0, 0, 8'h00, 8'h00);

        // 6: reset during the second beat
        d0 = done_cnt;
        start_stream(0, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_valid", 64'(out_valid), 64'(0));
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_index", 64'(out_index), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", 64'(done_cnt - d0), 64'(0));
        b0 = beats;
        start_stream(0, 3);
        wait_done(20);
        check("t6_rebeats", 64'(beats - b0), 64'(3));
        check("t6_drain", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
